fp_addsub_pipe: RTL

//  Parametrised, 3-stage pipelined IEEE-754 binary add/subtract (half default, single via params).

---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_lzc.sv | 17 +
 rtl/fp_addsub_pipe.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared constants for the FP add/sub datapath: flag bit positions, standard
// format widths, rounding-extension width and the canonical quiet-NaN pattern.
package fp_pkg;

    localparam int FLG_INV   = 4;
    localparam int FLG_DZ    = 3;
    localparam int FLG_UF    = 2;
    localparam int FLG_OF    = 1;
    localparam int FLG_NX    = 0;
    localparam int NUM_FLAGS = 5;

    localparam int HALF_EXP_W = 5;
    localparam int HALF_MAN_W = 10;
    localparam int SGL_EXP_W  = 8;
    localparam int SGL_MAN_W  = 23;

    localparam int GRS_W = 3;

    // {0, all-ones exponent, quiet bit, zeros}, right-aligned in 64 bits
    function automatic logic [63:0] canon_qnan(input int exp_w, input int man_w);
        logic [63:0] q;
        q = '0;
        for (int i = 0; i < exp_w; i++) q[man_w+i] = 1'b1;
        q[man_w-1] = 1'b1;
        return q;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 15,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] cnt
);

    // highest set bit is visited last and wins
    always_comb begin
        cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++)
            if (din[i]) cnt = CNT_W'(WIDTH - 1 - i);
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// 3-stage IEEE-754 add/subtract (align | add/sub | normalise+round), RNE, valid/ready.
// Define FP_ADDSUB_FTZ_EN to flush subnormal inputs and tiny results to signed zero.
import fp_pkg::*;

module fp_addsub_pipe #(
    parameter int EXP_W = HALF_EXP_W,
    parameter int MAN_W = HALF_MAN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_q,
    output logic [NUM_FLAGS-1:0]     out_flags
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int M      = MAN_W + 1 + GRS_W;
    localparam int LZ_W   = $clog2(M + 2);
    localparam int STAGES = 3;
    localparam logic [63:0]      QNAN64 = canon_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]     QNAN   = QNAN64[W-1:0];
    localparam logic [EXP_W-1:0] EMAX   = {EXP_W{1'b1}};

    logic              stall, en, accept;
    logic [STAGES:1]   vld_pipe;

    assign stall     = out_valid & ~out_ready;
    assign en        = ~stall;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign out_valid = vld_pipe[STAGES];

    // ---------------- S1: unpack, specials, swap, align ----------------
    logic             sa, sb, a_nan, b_nan, a_inf, b_inf, a_big;
    logic [EXP_W-1:0] ea, eb, big_e, small_e, big_ee, small_ee, diff;
    logic [MAN_W-1:0] ma, mb, big_f, small_f;
    logic [M-1:0]     big_m, small_m, small_sh, mask;
    logic [31:0]      diff32;
    logic             c1_spec, c1_inv, c1_sign, c1_sub;
    logic [W-1:0]     c1_spec_q;

    always_comb begin
        sa = in_a[W-1];
        sb = in_b[W-1] ^ in_sub;
        ea = in_a[W-2:MAN_W];
        eb = in_b[W-2:MAN_W];
        ma = in_a[MAN_W-1:0];
        mb = in_b[MAN_W-1:0];
        a_nan = (ea == EMAX) & (ma != '0);
        b_nan = (eb == EMAX) & (mb != '0);
        a_inf = (ea == EMAX) & (ma == '0);
        b_inf = (eb == EMAX) & (mb == '0);
`ifdef FP_ADDSUB_FTZ_EN
        if (ea == '0) ma = '0;
        if (eb == '0) mb = '0;
`endif
        a_big    = {ea, ma} >= {eb, mb};
        big_e    = a_big ? ea : eb;
        small_e  = a_big ? eb : ea;
        big_f    = a_big ? ma : mb;
        small_f  = a_big ? mb : ma;
        c1_sign  = a_big ? sa : sb;
        c1_sub   = sa ^ sb;
        big_ee   = (big_e == '0) ? EXP_W'(1) : big_e;
        small_ee = (small_e == '0) ? EXP_W'(1) : small_e;
        diff     = big_ee - small_ee;
        diff32   = 32'(diff);
        big_m    = {big_e != '0, big_f, {GRS_W{1'b0}}};
        small_m  = {small_e != '0, small_f, {GRS_W{1'b0}}};
        mask     = ~({M{1'b1}} << diff);
        if (diff32 >= M) begin
            small_sh    = '0;
            small_sh[0] = |small_m;
        end else begin
            small_sh    = small_m >> diff;
            small_sh[0] = small_sh[0] | (|(small_m & mask));
        end

        c1_spec   = a_nan | b_nan | a_inf | b_inf;
        c1_inv    = 1'b0;
        c1_spec_q = QNAN;
        if (a_nan | b_nan)
            c1_inv = (a_nan & ~ma[MAN_W-1]) | (b_nan & ~mb[MAN_W-1]);
        else if (a_inf & b_inf & c1_sub)
            c1_inv = 1'b1;
        else if (a_inf)
            c1_spec_q = {sa, EMAX, {MAN_W{1'b0}}};
        else if (b_inf)
            c1_spec_q = {sb, EMAX, {MAN_W{1'b0}}};
    end

    logic             s1_sign, s1_sub, s1_spec, s1_inv;
    logic [EXP_W-1:0] s1_exp;
    logic [M-1:0]     s1_big, s1_small;
    logic [W-1:0]     s1_spec_q;

    // ---------------- S2: add / subtract ----------------
    logic [M:0]       sum, c2_m;
    logic [EXP_W:0]   c2_exp;

    always_comb begin
        sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                     : ({1'b0, s1_big} + {1'b0, s1_small});
        // carry-out: renormalise right by one, folding the lost bit into sticky
        if (sum[M]) begin
            c2_m   = {1'b0, sum[M:2], sum[1] | sum[0]};
            c2_exp = {1'b0, s1_exp} + (EXP_W+1)'(1);
        end else begin
            c2_m   = sum;
            c2_exp = {1'b0, s1_exp};
        end
    end

    logic             s2_sign, s2_sub, s2_spec, s2_inv;
    logic [EXP_W:0]   s2_exp;
    logic [M:0]       s2_m;
    logic [W-1:0]     s2_spec_q;

    // ---------------- S3: normalise, round, pack ----------------
    logic [LZ_W-1:0]          lz;
    logic [31:0]              sh_want, sh_lim, sh;
    logic [M:0]               m_n;
    logic [EXP_W:0]           e_n, exp_pre, r_exp;
    logic [EXP_W+MAN_W:0]     rnd;
    logic                     up, nx, res_zero;
    logic [W-1:0]             res_q;
    logic [NUM_FLAGS-1:0]     res_f;

    fp_lzc #(.WIDTH(M + 1)) u_lzc (
        .din (s2_m),
        .cnt (lz)
    );

    always_comb begin
        // leading one belongs at bit M-1; never shift below the minimum exponent
        sh_want  = 32'(lz) - 32'd1;
        sh_lim   = 32'(s2_exp) - 32'd1;
        sh       = (sh_want < sh_lim) ? sh_want : sh_lim;
        m_n      = s2_m << sh;
        e_n      = s2_exp - sh[EXP_W:0];
        exp_pre  = m_n[M-1] ? e_n : '0;
        up       = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
        // rounding carry ripples into the exponent field (subnormal->normal, ->Inf)
        rnd      = {exp_pre, m_n[M-2:GRS_W]} + {{(EXP_W+MAN_W){1'b0}}, up};
        r_exp    = rnd[EXP_W+MAN_W:MAN_W];
        res_zero = (s2_m == '0);
        nx       = |m_n[GRS_W-1:0];
        res_q    = {s2_sign, r_exp[EXP_W-1:0], rnd[MAN_W-1:0]};
        res_f    = '0;
        res_f[FLG_NX] = nx;
        res_f[FLG_UF] = (r_exp == '0) & nx;
        if (r_exp >= {1'b0, EMAX}) begin
            res_q         = {s2_sign, EMAX, {MAN_W{1'b0}}};
            res_f[FLG_OF] = 1'b1;
            res_f[FLG_NX] = 1'b1;
        end
        if (res_zero)
            res_q = {s2_sub ? 1'b0 : s2_sign, {(W-1){1'b0}}};
`ifdef FP_ADDSUB_FTZ_EN
        else if (r_exp == '0) begin
            res_q         = {s2_sign, {(W-1){1'b0}}};
            res_f[FLG_UF] = 1'b1;
            res_f[FLG_NX] = 1'b1;
        end
`endif
        if (s2_spec) begin
            res_q          = s2_spec_q;
            res_f          = '0;
            res_f[FLG_INV] = s2_inv;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            out_q     <= '0;
            out_flags <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            if (vld_pipe[STAGES-1]) begin
                out_q     <= res_q;
                out_flags <= res_f;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_sign   <= c1_sign;
            s1_sub    <= c1_sub;
            s1_exp    <= big_ee;
            s1_big    <= big_m;
            s1_small  <= small_sh;
            s1_spec   <= c1_spec;
            s1_inv    <= c1_inv;
            s1_spec_q <= c1_spec_q;
            s2_sign   <= s1_sign;
            s2_sub    <= s1_sub;
            s2_exp    <= c2_exp;
            s2_m      <= c2_m;
            s2_spec   <= s1_spec;
            s2_inv    <= s1_inv;
            s2_spec_q <= s1_spec_q;
        end
    end

endmodule
